// File: rtl/mem_stage_sram_ctrl_pkg.sv
// mem_stage_sram_ctrl_pkg: shared state encoding, SRAM widths and default base address
package mem_stage_sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_e;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
endpackage

// File: rtl/mem_stage_sram_ctrl_sram_model.sv
// mem_stage_sram_ctrl_sram_model: behavioural 256K x 16 SRAM for simulation tops; writes sampled per clock
module mem_stage_sram_ctrl_sram_model
  import mem_stage_sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               ce_n,
  input  logic               oe_n,
  input  logic               we_n,
  input  logic               ub_n,
  input  logic               lb_n,
  input  logic [SRAM_AW-1:0] addr,
  inout  wire  [SRAM_DW-1:0] dq
);
  logic [SRAM_DW-1:0] mem_q [0:(1<<SRAM_AW)-1];
  assign dq = (!ce_n && !oe_n && we_n) ? mem_q[addr] : 'z;
  always_ff @(posedge clk) begin
    if (!ce_n && !we_n && !lb_n) mem_q[addr][7:0] <= dq[7:0];
    if (!ce_n && !we_n && !ub_n) mem_q[addr][15:8] <= dq[15:8];
  end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: 32-bit load/store over a 16-bit async SRAM as two timed half-word accesses
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic               ready,
  output logic [31:0]        read_data,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q;
  logic [16:0] word_q, word_d;
  logic [31:0] st_q, read_data_q;
  logic req, busy, last;
  assign req = MEM_R_EN | MEM_W_EN;
  assign word_d = 17'((ALU_result - BASE_ADDR) >> 2);
  assign busy = state_q == LOW || state_q == HIGH;
  assign last = cnt_q == 4'(ACCESS_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = busy && !last ? cnt_q + 4'd1 : 4'd0;
    case (state_q)
      IDLE: state_d = req ? LOW : IDLE;
      LOW:  state_d = last ? HIGH : LOW;
      HIGH: state_d = last ? DONE : HIGH;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      word_q <= '0;
      st_q <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && req) begin
        wr_q <= MEM_W_EN;
        word_q <= word_d;
        st_q <= ST_val;
      end
      if (busy && last && !wr_q && state_q == LOW) read_data_q[15:0] <= SRAM_DQ;
      if (busy && last && !wr_q && state_q == HIGH) read_data_q[31:16] <= SRAM_DQ;
    end
  end
  assign ready = (state_q == IDLE && !req) || state_q == DONE;
  assign read_data = read_data_q;
  assign SRAM_ADDR = busy ? {word_q, state_q == HIGH} : '0;
  // First HIGH cycle keeps WE_N high so the address change never sees an active write
  assign SRAM_WE_N = !(busy && wr_q && !(state_q == HIGH && cnt_q == 4'd0 && ACCESS_CYCLES > 1));
  assign SRAM_OE_N = !(busy && !wr_q);
  assign SRAM_DQ = (busy && wr_q) ? (state_q == HIGH ? st_q[31:16] : st_q[15:0]) : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
endmodule
